// File: rtl/l2_arbiter_if.sv
// Bus bundle between the two L1 caches, the L2 arbiter and the shared L2 port.
// The arbiter connects through the slave modport; the environment uses master.
interface l2_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  a_read;
  logic                  a_write;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [LINE_WIDTH-1:0] a_wdata;
  logic                  a_resp;
  logic [LINE_WIDTH-1:0] a_rdata;

  logic                  b_read;
  logic                  b_write;
  logic [ADDR_WIDTH-1:0] b_address;
  logic [LINE_WIDTH-1:0] b_wdata;
  logic                  b_resp;
  logic [LINE_WIDTH-1:0] b_rdata;

  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic                  l2_resp;
  logic [LINE_WIDTH-1:0] l2_rdata;

  logic                  stall_cache2_miss;

  modport slave (
    input  a_read, a_write, a_address, a_wdata,
    input  b_read, b_write, b_address, b_wdata,
    input  l2_resp, l2_rdata,
    output a_resp, a_rdata, b_resp, b_rdata,
    output l2_read, l2_write, l2_address, l2_wdata,
    output stall_cache2_miss
  );

  modport master (
    output a_read, a_write, a_address, a_wdata,
    output b_read, b_write, b_address, b_wdata,
    output l2_resp, l2_rdata,
    input  a_resp, a_rdata, b_resp, b_rdata,
    input  l2_read, l2_write, l2_address, l2_wdata,
    input  stall_cache2_miss
  );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-side (A) and D-side (B) L1s.
// One miss is in flight at a time; the granted request is latched so the L2 sees stable inputs.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic        clk,
  input logic        reset,
  l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_b, last_b_nxt;
  logic   a_req, b_req;
  logic   grant_a, grant_b;

  logic                  lat_read;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0] lat_wdata;

  assign a_req = bus.a_read | bus.a_write;
  assign b_req = bus.b_read | bus.b_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last_b <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_b <= last_b_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_b_nxt   = last_b;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    bus.l2_read  = 1'b0;
    bus.l2_write = 1'b0;
    bus.a_resp   = 1'b0;
    bus.b_resp   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (a_req && b_req) begin
          grant_a = last_b;
          grant_b = ~last_b;
        end else begin
          grant_a = a_req;
          grant_b = b_req;
        end
        if (grant_a) state_nxt = SERVE_A;
        else if (grant_b) state_nxt = SERVE_B;
      end
      SERVE_A: begin
        bus.l2_read  = lat_read;
        bus.l2_write = lat_write;
        if (bus.l2_resp) begin
          bus.a_resp = 1'b1;
          last_b_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      SERVE_B: begin
        bus.l2_read  = lat_read;
        bus.l2_write = lat_write;
        if (bus.l2_resp) begin
          bus.b_resp = 1'b1;
          last_b_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read+write together is treated as a write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant_a) begin
      lat_read  <= bus.a_read & ~bus.a_write;
      lat_write <= bus.a_write;
      lat_addr  <= bus.a_address;
      lat_wdata <= bus.a_wdata;
    end else if (grant_b) begin
      lat_read  <= bus.b_read & ~bus.b_write;
      lat_write <= bus.b_write;
      lat_addr  <= bus.b_address;
      lat_wdata <= bus.b_wdata;
    end
  end

  assign bus.l2_address = lat_addr;
  assign bus.l2_wdata   = lat_wdata;
  assign bus.a_rdata    = bus.l2_rdata;
  assign bus.b_rdata    = bus.l2_rdata;

  assign bus.stall_cache2_miss = b_req & ~((state == SERVE_B) & bus.l2_resp);

endmodule
